// File: rtl/ann_io_loader_pkg.sv
// ann_io_pkg: word width, tree/patch geometry, derived counts and FSM state
// encoding shared by the ANN pin-side loader files.
package ann_io_pkg;
  localparam int DATA_WIDTH     = 11;
  localparam int NUM_LEAVES     = 64;
  localparam int NUM_NODES      = NUM_LEAVES - 1;
  localparam int LEAF_SIZE      = 8;
  localparam int PATCH_SIZE     = 5;
  localparam int NUM_QUERYS     = 512;
  localparam int FIFO_DEPTH     = 8;

  // Derived geometry and stream word counts
  localparam int NUM_PATCHES    = NUM_LEAVES * LEAF_SIZE;
  localparam int LEAF_REC_WORDS = PATCH_SIZE + 1;
  localparam int NODE_WORDS     = 2 * NUM_NODES;
  localparam int LEAF_WORDS     = NUM_PATCHES * LEAF_REC_WORDS;
  localparam int QUERY_WORDS    = NUM_QUERYS * PATCH_SIZE;
  localparam int NODE_AW        = $clog2(NUM_LEAVES);
  localparam int PATCH_AW       = $clog2(NUM_PATCHES);
  localparam int QUERY_AW       = $clog2(NUM_QUERYS);
  // Record counter must hold NUM_QUERYS itself (end-of-send marker)
  localparam int CNT_W          = $clog2(NUM_QUERYS) + 1;
  localparam int FIFO_CW        = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NODES   = 3'd1,
    ST_LEAVES  = 3'd2,
    ST_QUERIES = 3'd3,
    ST_RUN     = 3'd4,
    ST_SEND    = 3'd5
  } state_e;
endpackage

// File: rtl/ann_io_loader_if.sv
// Pin, command and memory-port bundle of the ANN loader.
// Optional ANN_IO_OVERFLOW_EN adds the sticky in_overflow flag.
interface ann_io_loader_if import ann_io_pkg::*; ();
  logic                            load_kdtree, fsm_start, send_best_arr;
  logic                            in_fifo_wenq;
  logic [DATA_WIDTH-1:0]           in_fifo_wdata;
  logic                            in_fifo_wfull_n;
  logic                            out_fifo_deq;
  logic [DATA_WIDTH-1:0]           out_fifo_rdata;
  logic                            out_fifo_rempty_n;
  logic                            load_done, fsm_done, send_done;
  logic                            node_wen;
  logic [NODE_AW-1:0]              node_waddr;
  logic [2*DATA_WIDTH-1:0]         node_wdata;
  logic                            leaf_wen;
  logic [PATCH_AW-1:0]             leaf_waddr;
  logic [LEAF_REC_WORDS*DATA_WIDTH-1:0] leaf_wdata;
  logic                            query_wen;
  logic [QUERY_AW-1:0]             query_waddr;
  logic [PATCH_SIZE*DATA_WIDTH-1:0] query_wdata;
  logic                            comp_start, comp_done;
  logic [QUERY_AW-1:0]             best_raddr;
  logic [DATA_WIDTH-1:0]           best_rdata;
`ifdef ANN_IO_OVERFLOW_EN
  logic                            in_overflow;
`endif

  // Loader side
  modport slave (
    input  load_kdtree, fsm_start, send_best_arr, in_fifo_wenq, in_fifo_wdata,
           out_fifo_deq, comp_done, best_rdata,
    output in_fifo_wfull_n, out_fifo_rdata, out_fifo_rempty_n, load_done,
           fsm_done, send_done, node_wen, node_waddr, node_wdata, leaf_wen,
           leaf_waddr, leaf_wdata, query_wen, query_waddr, query_wdata,
           comp_start, best_raddr
`ifdef ANN_IO_OVERFLOW_EN
    , output in_overflow
`endif
  );

  // Pin / host side
  modport master (
    output load_kdtree, fsm_start, send_best_arr, in_fifo_wenq, in_fifo_wdata,
           out_fifo_deq, comp_done, best_rdata,
    input  in_fifo_wfull_n, out_fifo_rdata, out_fifo_rempty_n, load_done,
           fsm_done, send_done, node_wen, node_waddr, node_wdata, leaf_wen,
           leaf_waddr, leaf_wdata, query_wen, query_waddr, query_wdata,
           comp_start, best_raddr
`ifdef ANN_IO_OVERFLOW_EN
    , input in_overflow
`endif
  );
endinterface

// File: rtl/ann_io_loader_sync_fifo.sv
// ann_sync_fifo: single-clock first-word-fall-through FIFO. Push while full
// and pop while empty are ignored; the head reads as zero when empty.
module ann_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);
  assign rdata   = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers and occupancy; simultaneous push+pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/ann_io_loader.sv
// ann_io_loader: streams k-d tree nodes, leaf patches and queries from the
// input FIFO into memory write ports, kicks the search core, then drains the
// best-match array into the output FIFO. ANN_IO_OVERFLOW_EN adds in_overflow.
module ann_io_loader import ann_io_pkg::*; (
  input logic       io_clk,
  input logic       io_rst_n,
  ann_io_loader_if.slave bus
);
  logic [FIFO_CW-1:0] in_count, out_count;
  logic [DATA_WIDTH-1:0] in_word;
  logic in_full, in_empty, out_empty, in_pop, out_push, issue;

  state_e state_q, state_d;
  logic [2:0]       sub_q, sub_d;
  logic [CNT_W-1:0] item_q, item_d, issued_q, issued_d;
  logic pend_q, pend_d;
  logic load_done_q, load_done_d, fsm_done_q, fsm_done_d, send_done_q, send_done_d;
  logic comp_start_q, comp_start_d;
  logic node_wen_q, node_wen_d, leaf_wen_q, leaf_wen_d, query_wen_q, query_wen_d;
  logic [NODE_AW-1:0]  node_waddr_q, node_waddr_d;
  logic [PATCH_AW-1:0] leaf_waddr_q, leaf_waddr_d;
  logic [QUERY_AW-1:0] query_waddr_q, query_waddr_d;
  logic [2*DATA_WIDTH-1:0] node_wdata_q, node_wdata_d;
  logic [LEAF_REC_WORDS*DATA_WIDTH-1:0] leaf_wdata_q, leaf_wdata_d;
  logic [PATCH_SIZE*DATA_WIDTH-1:0] query_wdata_q, query_wdata_d;
  // Word k of the record being assembled sits in buf_q[k]
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] buf_q;

  ann_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk(io_clk), .rst_n(io_rst_n), .push(bus.in_fifo_wenq), .pop(in_pop),
    .wdata(bus.in_fifo_wdata), .rdata(in_word), .count(in_count));

  ann_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk(io_clk), .rst_n(io_rst_n), .push(out_push), .pop(bus.out_fifo_deq),
    .wdata(bus.best_rdata), .rdata(bus.out_fifo_rdata), .count(out_count));

  assign in_full   = (in_count == FIFO_CW'(FIFO_DEPTH));
  assign in_empty  = (in_count == '0);
  assign out_empty = (out_count == '0);

  // Next-state: stream decoding, compute handshake and result drain
  always_comb begin
    state_d = state_q;  sub_d = sub_q;  item_d = item_q;
    issued_d = issued_q;  pend_d = pend_q;
    load_done_d = load_done_q;  fsm_done_d = fsm_done_q;  send_done_d = send_done_q;
    comp_start_d = 1'b0;
    node_wen_d = 1'b0;  node_waddr_d = node_waddr_q;  node_wdata_d = node_wdata_q;
    leaf_wen_d = 1'b0;  leaf_waddr_d = leaf_waddr_q;  leaf_wdata_d = leaf_wdata_q;
    query_wen_d = 1'b0; query_waddr_d = query_waddr_q; query_wdata_d = query_wdata_q;
    out_push = 1'b0;
    issue = 1'b0;
    // The input FIFO is held (not drained) while computing or sending
    in_pop = !in_empty && !bus.load_kdtree &&
             (state_q inside {ST_IDLE, ST_NODES, ST_LEAVES, ST_QUERIES});
    case (state_q)
      ST_IDLE: begin
        if (bus.fsm_start) begin
          comp_start_d = 1'b1;
          state_d = ST_RUN;
        end else if (bus.send_best_arr) begin
          issued_d = '0;
          pend_d = 1'b0;
          state_d = ST_SEND;
        end
      end
      ST_NODES: if (in_pop) begin
        if (sub_q == 3'd0) sub_d = 3'd1;
        else begin
          // Only the low 3 bits of the split index are meaningful
          node_wen_d = 1'b1;
          node_waddr_d = item_q[NODE_AW-1:0];
          node_wdata_d = {in_word, {(DATA_WIDTH-3){1'b0}}, buf_q[0][2:0]};
          sub_d = 3'd0;
          if (item_q == CNT_W'(NUM_NODES-1)) begin
            item_d = '0;
            state_d = ST_LEAVES;
          end else item_d = item_q + CNT_W'(1);
        end
      end
      ST_LEAVES: if (in_pop) begin
        if (sub_q != 3'(LEAF_REC_WORDS-1)) sub_d = sub_q + 3'd1;
        else begin
          leaf_wen_d = 1'b1;
          leaf_waddr_d = item_q[PATCH_AW-1:0];
          leaf_wdata_d = {in_word, buf_q};
          sub_d = 3'd0;
          if (item_q == CNT_W'(NUM_PATCHES-1)) begin
            item_d = '0;
            load_done_d = 1'b1;
            state_d = ST_QUERIES;
          end else item_d = item_q + CNT_W'(1);
        end
      end
      ST_QUERIES: if (in_pop) begin
        if (sub_q != 3'(PATCH_SIZE-1)) sub_d = sub_q + 3'd1;
        else begin
          query_wen_d = 1'b1;
          query_waddr_d = item_q[QUERY_AW-1:0];
          query_wdata_d = {in_word, buf_q[PATCH_SIZE-2:0]};
          sub_d = 3'd0;
          if (item_q == CNT_W'(NUM_QUERYS-1)) begin
            item_d = '0;
            state_d = ST_IDLE;
          end else item_d = item_q + CNT_W'(1);
        end
      end
      ST_RUN: if (bus.comp_done) begin
        fsm_done_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_SEND: begin
        // Read data lands one cycle after its address; two free slots cover
        // the word already in flight plus the one being requested now.
        out_push = pend_q;
        issue = (issued_q < CNT_W'(NUM_QUERYS)) &&
                (out_count <= FIFO_CW'(FIFO_DEPTH-2));
        pend_d = issue;
        if (issue) issued_d = issued_q + CNT_W'(1);
        if (pend_q && (issued_q == CNT_W'(NUM_QUERYS))) begin
          send_done_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new tree load pre-empts whatever is running
    if (bus.load_kdtree) begin
      state_d = ST_NODES;
      sub_d = '0;  item_d = '0;  issued_d = '0;  pend_d = 1'b0;
      load_done_d = 1'b0;  fsm_done_d = 1'b0;  send_done_d = 1'b0;
      out_push = 1'b0;
    end
  end

  // Control and write-port registers
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q <= ST_IDLE;  sub_q <= '0;  item_q <= '0;  issued_q <= '0;  pend_q <= 1'b0;
      load_done_q <= 1'b0;  fsm_done_q <= 1'b0;  send_done_q <= 1'b0;  comp_start_q <= 1'b0;
      node_wen_q <= 1'b0;   node_waddr_q <= '0;  node_wdata_q <= '0;
      leaf_wen_q <= 1'b0;   leaf_waddr_q <= '0;  leaf_wdata_q <= '0;
      query_wen_q <= 1'b0;  query_waddr_q <= '0; query_wdata_q <= '0;
    end else begin
      state_q <= state_d;  sub_q <= sub_d;  item_q <= item_d;  issued_q <= issued_d;  pend_q <= pend_d;
      load_done_q <= load_done_d;  fsm_done_q <= fsm_done_d;  send_done_q <= send_done_d;
      comp_start_q <= comp_start_d;
      node_wen_q <= node_wen_d;    node_waddr_q <= node_waddr_d;   node_wdata_q <= node_wdata_d;
      leaf_wen_q <= leaf_wen_d;    leaf_waddr_q <= leaf_waddr_d;   leaf_wdata_q <= leaf_wdata_d;
      query_wen_q <= query_wen_d;  query_waddr_q <= query_waddr_d; query_wdata_q <= query_wdata_d;
    end
  end

  // Capture each popped word into its slot of the record buffer
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) buf_q <= '0;
    else if (in_pop) begin
      for (int i = 0; i < PATCH_SIZE; i++)
        if (sub_q == 3'(i)) buf_q[i] <= in_word;
    end
  end

`ifdef ANN_IO_OVERFLOW_EN
  logic ovf_q;
  // Sticky record of any dropped push or ignored pop
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) ovf_q <= 1'b0;
    else if (bus.load_kdtree) ovf_q <= 1'b0;
    else if ((bus.in_fifo_wenq && in_full) || (bus.out_fifo_deq && out_empty)) ovf_q <= 1'b1;
  end
  assign bus.in_overflow = ovf_q;
`endif

  assign bus.in_fifo_wfull_n   = !in_full;
  assign bus.out_fifo_rempty_n = !out_empty;
  assign bus.load_done   = load_done_q;
  assign bus.fsm_done    = fsm_done_q;
  assign bus.send_done   = send_done_q;
  assign bus.comp_start  = comp_start_q;
  assign bus.best_raddr  = issued_q[QUERY_AW-1:0];
  assign bus.node_wen    = node_wen_q;
  assign bus.node_waddr  = node_waddr_q;
  assign bus.node_wdata  = node_wdata_q;
  assign bus.leaf_wen    = leaf_wen_q;
  assign bus.leaf_waddr  = leaf_waddr_q;
  assign bus.leaf_wdata  = leaf_wdata_q;
  assign bus.query_wen   = query_wen_q;
  assign bus.query_waddr = query_waddr_q;
  assign bus.query_wdata = query_wdata_q;
endmodule

// File: tb/tb_ann_io_loader.sv
// Directed bench for ann_io_loader: load stream, compute handshake, input
// back-pressure, result drain, async reset and load restart.
module tb_ann_io_loader;
  import ann_io_pkg::*;

  logic io_clk = 1'b0;
  logic io_rst_n = 1'b0;
  always #5 io_clk = ~io_clk;

  ann_io_loader_if bus();
  ann_io_loader dut (.io_clk(io_clk), .io_rst_n(io_rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Best-match memory model: registered read returning its own address
  always @(posedge io_clk) bus.best_rdata <= DATA_WIDTH'(bus.best_raddr);

  // Write-port monitor
  int node_cnt = 0, leaf_cnt = 0, query_cnt = 0, addr_err = 0;
  logic [21:0] node1, node5, node62, node_last;
  logic [65:0] leaf_first, leaf_last;
  logic [54:0] q_first, q_last;
  logic ld_at_510, ld_at_511;
  always @(negedge io_clk) begin
    if (bus.node_wen) begin
      if (bus.node_waddr !== NODE_AW'(node_cnt % NUM_NODES)) addr_err <= addr_err + 1;
      if (node_cnt == 1)  node1  <= bus.node_wdata;
      if (node_cnt == 5)  node5  <= bus.node_wdata;
      if (node_cnt == 62) node62 <= bus.node_wdata;
      node_last <= bus.node_wdata;
      node_cnt <= node_cnt + 1;
    end
    if (bus.leaf_wen) begin
      if (bus.leaf_waddr !== PATCH_AW'(leaf_cnt % NUM_PATCHES)) addr_err <= addr_err + 1;
      if (leaf_cnt == 0)   leaf_first <= bus.leaf_wdata;
      if (leaf_cnt == 510) ld_at_510 <= bus.load_done;
      if (leaf_cnt == 511) begin leaf_last <= bus.leaf_wdata; ld_at_511 <= bus.load_done; end
      leaf_cnt <= leaf_cnt + 1;
    end
    if (bus.query_wen) begin
      if (bus.query_waddr !== QUERY_AW'(query_cnt % NUM_QUERYS)) addr_err <= addr_err + 1;
      if (query_cnt == 0)   q_first <= bus.query_wdata;
      if (query_cnt == 511) q_last <= bus.query_wdata;
      query_cnt <= query_cnt + 1;
    end
  end

  task automatic strobe(input int sel);
    @(negedge io_clk);
    case (sel)
      0: bus.load_kdtree = 1'b1;
      1: bus.fsm_start = 1'b1;
      default: bus.send_best_arr = 1'b1;
    endcase
    @(negedge io_clk);
    bus.load_kdtree = 1'b0; bus.fsm_start = 1'b0; bus.send_best_arr = 1'b0;
  endtask

  // Push words 0..n-1 (truncated to 11 bits), honouring wfull_n
  task automatic push_stream(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      @(negedge io_clk);
      bus.in_fifo_wenq = 1'b0;
      guard = 0;
      while (!bus.in_fifo_wfull_n && guard < 100) begin @(negedge io_clk); guard++; end
      bus.in_fifo_wenq = 1'b1;
      bus.in_fifo_wdata = DATA_WIDTH'(i);
    end
    @(negedge io_clk);
    bus.in_fifo_wenq = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge io_clk);
    checks++; if (bus.in_fifo_wfull_n !== 1'b1) begin failures++; $display("FAIL rst_wfull_n got=%b exp=1", bus.in_fifo_wfull_n); end
    checks++; if (bus.out_fifo_rempty_n !== 1'b0) begin failures++; $display("FAIL rst_rempty_n got=%b exp=0", bus.out_fifo_rempty_n); end
    checks++; if (bus.out_fifo_rdata !== 11'd0) begin failures++; $display("FAIL rst_rdata got=%0d exp=0", bus.out_fifo_rdata); end
    checks++; if ({bus.load_done, bus.fsm_done, bus.send_done} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {bus.load_done, bus.fsm_done, bus.send_done}); end
    checks++; if ({bus.node_wen, bus.leaf_wen, bus.query_wen, bus.comp_start} !== 4'b0000) begin failures++; $display("FAIL rst_strobes got=%b exp=0000", {bus.node_wen, bus.leaf_wen, bus.query_wen, bus.comp_start}); end
    io_rst_n = 1'b1;
    repeat (2) @(negedge io_clk);
    checks++; if (bus.in_fifo_wfull_n !== 1'b1 || bus.out_fifo_rempty_n !== 1'b0) begin failures++; $display("FAIL post_rst_fifo got=%b%b exp=10", bus.in_fifo_wfull_n, bus.out_fifo_rempty_n); end
    $display("reset released");
  endtask

  task automatic test_nodes();
    strobe(0);
    push_stream(2 * NUM_NODES);
    repeat (5) @(negedge io_clk);
    checks++; if (node_cnt !== 63) begin failures++; $display("FAIL node_count got=%0d exp=63", node_cnt); end
    checks++; if (node1 !== {11'd3, 11'd2}) begin failures++; $display("FAIL node1 got=%h exp=%h", node1, {11'd3, 11'd2}); end
    checks++; if (node5 !== {11'd11, 11'd2}) begin failures++; $display("FAIL node5_idx_mask got=%h exp=%h", node5, {11'd11, 11'd2}); end
    checks++; if (node62 !== {11'd125, 11'd4}) begin failures++; $display("FAIL node62 got=%h exp=%h", node62, {11'd125, 11'd4}); end
    checks++; if (bus.load_done !== 1'b0 || leaf_cnt !== 0) begin failures++; $display("FAIL nodes_no_leaf got ld=%b leaves=%0d exp 0/0", bus.load_done, leaf_cnt); end
    $display("nodes loaded: %0d writes", node_cnt);
  endtask

  task automatic test_leaves();
    push_stream(NUM_PATCHES * LEAF_REC_WORDS);
    repeat (5) @(negedge io_clk);
    checks++; if (leaf_cnt !== 512) begin failures++; $display("FAIL leaf_count got=%0d exp=512", leaf_cnt); end
    checks++; if (leaf_first !== {11'd5, 11'd4, 11'd3, 11'd2, 11'd1, 11'd0}) begin failures++; $display("FAIL leaf_first got=%h", leaf_first); end
    checks++; if (leaf_last !== {11'd1023, 11'd1022, 11'd1021, 11'd1020, 11'd1019, 11'd1018}) begin failures++; $display("FAIL leaf_last got=%h", leaf_last); end
    checks++; if ({ld_at_510, ld_at_511} !== 2'b01) begin failures++; $display("FAIL load_done_edge got=%b exp=01", {ld_at_510, ld_at_511}); end
    checks++; if (bus.load_done !== 1'b1 || query_cnt !== 0) begin failures++; $display("FAIL leaves_done got ld=%b q=%0d exp 1/0", bus.load_done, query_cnt); end
    $display("leaves loaded: %0d writes", leaf_cnt);
  endtask

  task automatic test_queries();
    push_stream(NUM_QUERYS * PATCH_SIZE);
    repeat (5) @(negedge io_clk);
    checks++; if (query_cnt !== 512) begin failures++; $display("FAIL query_count got=%0d exp=512", query_cnt); end
    checks++; if (q_first !== {11'd4, 11'd3, 11'd2, 11'd1, 11'd0}) begin failures++; $display("FAIL query_first got=%h", q_first); end
    checks++; if (q_last !== {11'd511, 11'd510, 11'd509, 11'd508, 11'd507}) begin failures++; $display("FAIL query_last got=%h", q_last); end
    // Back in IDLE: further words are discarded
    push_stream(3);
    repeat (5) @(negedge io_clk);
    checks++; if (node_cnt !== 63 || leaf_cnt !== 512 || query_cnt !== 512) begin failures++; $display("FAIL idle_discard got=%0d/%0d/%0d", node_cnt, leaf_cnt, query_cnt); end
    checks++; if (addr_err !== 0) begin failures++; $display("FAIL write_addr_seq got=%0d exp=0", addr_err); end
    $display("queries loaded: %0d writes", query_cnt);
  endtask

  task automatic test_compute_full();
    strobe(1);
    checks++; if (bus.comp_start !== 1'b1) begin failures++; $display("FAIL comp_start_hi got=%b exp=1", bus.comp_start); end
    @(negedge io_clk);
    checks++; if (bus.comp_start !== 1'b0) begin failures++; $display("FAIL comp_start_lo got=%b exp=0", bus.comp_start); end
    // Loader is not draining while the core runs
    for (int k = 0; k < 9; k++) begin
      bus.in_fifo_wenq = 1'b1;
      bus.in_fifo_wdata = DATA_WIDTH'(k);
      @(negedge io_clk);
      if (k == 6) begin checks++; if (bus.in_fifo_wfull_n !== 1'b1) begin failures++; $display("FAIL wfull_n_at7 got=%b exp=1", bus.in_fifo_wfull_n); end end
      if (k == 7) begin checks++; if (bus.in_fifo_wfull_n !== 1'b0) begin failures++; $display("FAIL wfull_n_at8 got=%b exp=0", bus.in_fifo_wfull_n); end end
    end
    bus.in_fifo_wenq = 1'b0;
`ifdef ANN_IO_OVERFLOW_EN
    checks++; if (bus.in_overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", bus.in_overflow); end
`endif
    checks++; if (bus.fsm_done !== 1'b0) begin failures++; $display("FAIL fsm_done_early got=%b exp=0", bus.fsm_done); end
    repeat (8) @(negedge io_clk);
    bus.comp_done = 1'b1;
    @(negedge io_clk);
    bus.comp_done = 1'b0;
    checks++; if (bus.fsm_done !== 1'b1) begin failures++; $display("FAIL fsm_done got=%b exp=1", bus.fsm_done); end
    repeat (15) @(negedge io_clk);
    checks++; if (bus.in_fifo_wfull_n !== 1'b1 || node_cnt !== 63) begin failures++; $display("FAIL drain_discard got wfull_n=%b nodes=%0d exp 1/63", bus.in_fifo_wfull_n, node_cnt); end
    $display("compute done, input FIFO drained");
  endtask

  task automatic test_send();
    int got, cyc;
    strobe(2);
    repeat (20) @(negedge io_clk);
    checks++; if (bus.out_fifo_rempty_n !== 1'b1 || bus.out_fifo_rdata !== 11'd0) begin failures++; $display("FAIL send_head got=%b/%0d exp 1/0", bus.out_fifo_rempty_n, bus.out_fifo_rdata); end
    checks++; if (bus.best_raddr !== 9'd8) begin failures++; $display("FAIL send_stall_addr got=%0d exp=8", bus.best_raddr); end
    repeat (5) @(negedge io_clk);
    checks++; if (bus.best_raddr !== 9'd8 || bus.send_done !== 1'b0) begin failures++; $display("FAIL send_stall_hold got addr=%0d done=%b exp 8/0", bus.best_raddr, bus.send_done); end
    got = 0; cyc = 0;
    while (got < NUM_QUERYS && cyc < 5000) begin
      if (bus.out_fifo_rempty_n) begin
        checks++;
        if (bus.out_fifo_rdata !== DATA_WIDTH'(got)) begin failures++; $display("FAIL send_word got=%0d exp=%0d", bus.out_fifo_rdata, got); end
        got++;
        bus.out_fifo_deq = 1'b1;
      end else bus.out_fifo_deq = 1'b0;
      @(negedge io_clk);
      cyc++;
    end
    bus.out_fifo_deq = 1'b0;
    checks++; if (got !== NUM_QUERYS) begin failures++; $display("FAIL send_timeout got=%0d exp=512", got); end
    checks++; if (bus.send_done !== 1'b1 || bus.out_fifo_rempty_n !== 1'b0) begin failures++; $display("FAIL send_done got=%b empty_n=%b exp 1/0", bus.send_done, bus.out_fifo_rempty_n); end
    $display("send drained %0d words", got);
  endtask

  task automatic test_async_reset();
    @(negedge io_clk);
    #2 io_rst_n = 1'b0;
    #1;
    checks++; if ({bus.load_done, bus.fsm_done, bus.send_done} !== 3'b000) begin failures++; $display("FAIL async_rst_flags got=%b exp=000", {bus.load_done, bus.fsm_done, bus.send_done}); end
    @(negedge io_clk);
    io_rst_n = 1'b1;
    $display("async reset applied");
  endtask

  task automatic test_restart();
    strobe(1);
    repeat (3) @(negedge io_clk);
    bus.comp_done = 1'b1;
    @(negedge io_clk);
    bus.comp_done = 1'b0;
    checks++; if (bus.fsm_done !== 1'b1) begin failures++; $display("FAIL restart_pre got=%b exp=1", bus.fsm_done); end
    strobe(0);
    checks++; if (bus.fsm_done !== 1'b0) begin failures++; $display("FAIL restart_clear got=%b exp=0", bus.fsm_done); end
`ifdef ANN_IO_OVERFLOW_EN
    checks++; if (bus.in_overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear got=%b exp=0", bus.in_overflow); end
`endif
    push_stream(2);
    repeat (4) @(negedge io_clk);
    checks++; if (node_cnt !== 64 || node_last !== {11'd1, 11'd0}) begin failures++; $display("FAIL restart_node got cnt=%0d data=%h exp 64/%h", node_cnt, node_last, {11'd1, 11'd0}); end
    checks++; if (addr_err !== 0) begin failures++; $display("FAIL restart_addr got=%0d exp=0", addr_err); end
    $display("load restarted");
  endtask

  initial begin
    bus.load_kdtree = 1'b0; bus.fsm_start = 1'b0; bus.send_best_arr = 1'b0;
    bus.in_fifo_wenq = 1'b0; bus.in_fifo_wdata = '0; bus.out_fifo_deq = 1'b0;
    bus.comp_done = 1'b0;
    test_reset();
    test_nodes();
    test_leaves();
    test_queries();
    test_compute_full();
    test_send();
    test_async_reset();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
